// File: rtl/fifo_multichannel_pkg.sv
// Shared types for the multichannel FIFO bank and its round-robin drain.
// Default widths describe the standard bank configuration.
package fifo_multichannel_pkg;

    localparam int DEF_RAM_WIDTH = 32;
    localparam int DEF_FIFOS_CNT = 5;
    localparam int DEF_BURST_LEN = 16;

    typedef logic [$clog2(DEF_FIFOS_CNT)-1:0] chan_id_t;

    // Field order of a tagged word; the drain packs {data, chan, last} the same way for any width.
    typedef struct packed {
        logic [DEF_RAM_WIDTH-1:0] data;
        chan_id_t                 chan;
        logic                     last;
    } tagged_word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BURST = 2'd2
    } drain_state_e;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry output buffer with registered valid/ready; entry 0 is always the oldest word.
module stream_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] ent0_q;
    logic [WIDTH-1:0] ent1_q;
    logic [1:0]       occ_q;
    logic             push;
    logic             pop;

    assign in_ready  = (occ_q != 2'd2);
    assign out_valid = (occ_q != 2'd0);
    assign out_data  = ent0_q;
    assign occ       = occ_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // NOTE: <= makes every register sample pre-edge values, which the ent0 <= ent1 shift depends on.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the two entries are reset as well as occ so the visible data word reads 0 out of reset.
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) ent0_q <= in_data;
                    else               ent1_q <= in_data;
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    ent0_q <= ent1_q;
                    occ_q  <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        ent0_q <= in_data;
                    end else begin
                        ent0_q <= ent1_q;
                        ent1_q <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_channel_drain_rr.sv
// Round-robin drain of the multichannel FIFO bank into one tagged stream (data, channel, last).
// Bursts of up to BURST_LEN reads per grant, credit-limited so the 2-entry skid never overflows.
module fifo_channel_drain_rr
    import fifo_multichannel_pkg::*;
#(
    parameter int RAM_WIDTH = DEF_RAM_WIDTH,
    parameter int FIFOS_CNT = DEF_FIFOS_CNT,
    parameter int BURST_LEN = DEF_BURST_LEN
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [FIFOS_CNT-1:0]           i_empty_channels,
    output logic [FIFOS_CNT-1:0]           o_rd_en_channels,
    input  logic [FIFOS_CNT-1:0]           i_rd_valid_channels,
    input  logic [FIFOS_CNT*RAM_WIDTH-1:0] i_rd_data_channels,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [RAM_WIDTH-1:0]           o_data,
    output logic [$clog2(FIFOS_CNT)-1:0]   o_channel,
    output logic                           o_last,
    output logic                           o_busy
);

    localparam int CHAN_W = $clog2(FIFOS_CNT);
    localparam int BEAT_W = $clog2(BURST_LEN + 1);
    localparam int TAG_W  = RAM_WIDTH + CHAN_W + 1;

    drain_state_e      state_q, state_d;
    logic [CHAN_W-1:0] rr_ptr_q, gnt_id_q, pick_id, inflight_chan_q;
    logic [BEAT_W-1:0] beat_cnt_q;
    logic              pick_found, inflight_q, inflight_last_q;
    logic              pop, push, issue, credit_ok, gnt_empty, beat_final, skid_in_ready;
    logic [1:0]        skid_occ;
    logic [2:0]        credit_used;
    logic [TAG_W-1:0]  push_word, out_word;
    logic [RAM_WIDTH-1:0] rd_data_arr [FIFOS_CNT];

    for (genvar c = 0; c < FIFOS_CNT; c++) begin : g_unpack
        assign rd_data_arr[c] = i_rd_data_channels[c*RAM_WIDTH +: RAM_WIDTH];
    end

    // First non-empty channel at or after rr_ptr, wrapping modulo FIFOS_CNT.
    always_comb begin
        int idx;
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        pick_found = 1'b0;
        pick_id    = '0;
        idx        = 0;
        for (int k = 0; k < FIFOS_CNT; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= FIFOS_CNT) idx = idx - FIFOS_CNT;
            if (!pick_found && !i_empty_channels[CHAN_W'(idx)]) begin
                pick_found = 1'b1;
                pick_id    = CHAN_W'(idx);
            end
        end
    end

    // Words already committed (buffered or returning) minus the one leaving this cycle.
    assign pop         = o_valid & i_ready;
    assign credit_used = {1'b0, skid_occ} + {2'b00, inflight_q} - {2'b00, pop};
    assign credit_ok   = (credit_used < 3'd2);
    assign gnt_empty   = i_empty_channels[gnt_id_q];
    assign issue       = (state_q == BURST) && !gnt_empty && credit_ok;
    assign beat_final  = (beat_cnt_q == BEAT_W'(BURST_LEN - 1));

    assign o_rd_en_channels = issue ? (FIFOS_CNT'(1) << gnt_id_q) : '0;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick_found) state_d = GRANT;
            GRANT:   state_d = BURST;
            BURST:   if ((issue && beat_final) || (!issue && gnt_empty)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            rr_ptr_q        <= '0;
            gnt_id_q        <= '0;
            beat_cnt_q      <= '0;
            inflight_q      <= 1'b0;
            inflight_chan_q <= '0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && pick_found) gnt_id_q <= pick_id;
            if (state_q == GRANT) begin
                beat_cnt_q <= '0;
                rr_ptr_q   <= CHAN_W'(wrap_inc(int'(gnt_id_q), FIFOS_CNT));
            end else if (issue) begin
                beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
            end
            inflight_q <= issue;
            if (issue) begin
                inflight_chan_q <= gnt_id_q;
                inflight_last_q <= beat_final;
            end
        end
    end

    // The empty flag seen when the data returns already reflects this read, so it marks the final word.
    assign push      = inflight_q && i_rd_valid_channels[inflight_chan_q];
    assign push_word = {rd_data_arr[inflight_chan_q], inflight_chan_q,
                        inflight_last_q | i_empty_channels[inflight_chan_q]};

    stream_skid_buffer #(
        .WIDTH (TAG_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (push),
        .in_ready  (skid_in_ready),
        .in_data   (push_word),
        .out_valid (o_valid),
        .out_ready (i_ready),
        .out_data  (out_word),
        .occ       (skid_occ)
    );

    assign {o_data, o_channel, o_last} = out_word;
    assign o_busy = (state_q != IDLE) | inflight_q | (skid_occ != 2'd0);

    a_skid_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) push |-> skid_in_ready);

endmodule

// File: tb/tb_fifo_channel_drain_rr.sv
// Bench for fifo_channel_drain_rr: FIFO-bank model driving the inputs, grant-level reference stream.
module tb_fifo_channel_drain_rr;

    localparam int RAM_WIDTH = 32;
    localparam int FIFOS_CNT = 5;
    localparam int BURST_LEN = 16;
    localparam int CHAN_W    = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                           rst_n;
    logic [FIFOS_CNT-1:0]           i_empty_channels;
    logic [FIFOS_CNT-1:0]           o_rd_en_channels;
    logic [FIFOS_CNT-1:0]           i_rd_valid_channels;
    logic [FIFOS_CNT*RAM_WIDTH-1:0] i_rd_data_channels;
    logic                           o_valid;
    logic                           i_ready;
    logic [RAM_WIDTH-1:0]           o_data;
    logic [CHAN_W-1:0]              o_channel;
    logic                           o_last;
    logic                           o_busy;

    fifo_channel_drain_rr #(
        .RAM_WIDTH (RAM_WIDTH),
        .FIFOS_CNT (FIFOS_CNT),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_empty_channels    (i_empty_channels),
        .o_rd_en_channels    (o_rd_en_channels),
        .i_rd_valid_channels (i_rd_valid_channels),
        .i_rd_data_channels  (i_rd_data_channels),
        .o_valid             (o_valid),
        .i_ready             (i_ready),
        .o_data              (o_data),
        .o_channel           (o_channel),
        .o_last              (o_last),
        .o_busy              (o_busy)
    );

    typedef struct packed {
        logic [RAM_WIDTH-1:0] data;
        logic [CHAN_W-1:0]    chan;
        logic                 last;
    } word_t;

    logic [RAM_WIDTH-1:0] bank [FIFOS_CNT][$];
    word_t exp_q[$];
    int    checks = 0, failures = 0;
    int    cyc = 0, mdl_ptr = 0, outstanding = 0, ready_pct = 100;
    int    reads_per_chan [FIFOS_CNT];
    logic  rst_n_next;
    logic  stalled_prev, tput_on, have_prev, prev_last;
    word_t stall_word;
    int    prev_cyc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input int ch, input int n);
        repeat (n) bank[ch].push_back($urandom());
    endtask

    // Grant-level reference: each grant takes min(BURST_LEN, remaining) words from the next non-empty channel.
    task automatic build_expected();
        int taken [FIFOS_CNT];
        int c, n, c2;
        bit found, more;
        foreach (taken[i]) taken[i] = 0;
        more = 1'b1;
        while (more) begin
            found = 1'b0;
            c = 0;
            for (int k = 0; k < FIFOS_CNT; k++) begin
                c2 = (mdl_ptr + k) % FIFOS_CNT;
                if (!found && taken[c2] < bank[c2].size()) begin
                    found = 1'b1;
                    c = c2;
                end
            end
            if (!found) begin
                more = 1'b0;
            end else begin
                n = bank[c].size() - taken[c];
                if (n > BURST_LEN) n = BURST_LEN;
                for (int j = 0; j < n; j++)
                    exp_q.push_back('{data: bank[c][taken[c] + j], chan: CHAN_W'(c), last: (j == n - 1)});
                taken[c] += n;
                mdl_ptr = (c + 1) % FIFOS_CNT;
            end
        end
    endtask

    // One clock: sample at negedge, account for the coming edge, drive the bank's response after it.
    task automatic cycle();
        logic [FIFOS_CNT-1:0]           rd, new_valid;
        logic [FIFOS_CNT*RAM_WIDTH-1:0] new_data;
        logic                           acc;
        word_t                          got, e;
        rd  = o_rd_en_channels;
        acc = rst_n && o_valid && i_ready;
        got = '{data: o_data, chan: o_channel, last: o_last};
        if (rst_n && stalled_prev) begin
            check("stall_valid", 64'(o_valid), 64'(1));
            check("stall_hold", 64'(got), 64'(stall_word));
        end
        stalled_prev = rst_n && o_valid && !i_ready;
        stall_word   = got;
        check("rd_en_onehot", 64'($countones(rd) <= 1), 64'(1));
        if (acc) begin
            check("word_expected", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out_data", 64'(o_data), 64'(e.data));
                check("out_channel", 64'(o_channel), 64'(e.chan));
                check("out_last", 64'(o_last), 64'(e.last));
            end
            if (tput_on && have_prev && !prev_last) check("tput_gap", 64'(cyc - prev_cyc), 64'(1));
            have_prev = 1'b1;
            prev_last = o_last;
            prev_cyc  = cyc;
        end
        new_valid = '0;
        new_data  = '0;
        for (int c = 0; c < FIFOS_CNT; c++) begin
            if (rd[c]) begin
                check("read_nonempty", 64'(bank[c].size() > 0), 64'(1));
                if (bank[c].size() > 0) new_data[c*RAM_WIDTH +: RAM_WIDTH] = bank[c].pop_front();
                new_valid[c] = 1'b1;
                reads_per_chan[c]++;
            end
        end
        if (!rst_n) begin
            outstanding = 0;
        end else begin
            outstanding = outstanding + $countones(rd) - int'(acc);
            check("buffered_le2", 64'(outstanding <= 2), 64'(1));
        end
        @(posedge clk);
        #1;
        cyc++;
        i_rd_valid_channels = new_valid;
        i_rd_data_channels  = new_data;
        for (int c = 0; c < FIFOS_CNT; c++) i_empty_channels[c] = (bank[c].size() == 0);
        i_ready = ($urandom_range(0, 99) < ready_pct);
        rst_n   = rst_n_next;
        @(negedge clk);
    endtask

    task automatic drain(input int budget, input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || o_busy) && n < budget) begin
            cycle();
            n++;
        end
        check({tag, "_all_words"}, 64'(exp_q.size()), 64'(0));
        check({tag, "_idle"}, 64'(o_busy), 64'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"}, 64'(o_rd_en_channels), 64'(0));
        check({tag, "_valid"}, 64'(o_valid), 64'(0));
        check({tag, "_data"}, 64'(o_data), 64'(0));
        check({tag, "_channel"}, 64'(o_channel), 64'(0));
        check({tag, "_last"}, 64'(o_last), 64'(0));
        check({tag, "_busy"}, 64'(o_busy), 64'(0));
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        rst_n_next = 1'b0;
        i_ready = 1'b1;
        i_rd_valid_channels = '0;
        i_rd_data_channels = '0;
        stalled_prev = 1'b0;
        tput_on = 1'b0;
        have_prev = 1'b0;
        prev_last = 1'b0;
        prev_cyc = 0;
        stall_word = '0;
        foreach (reads_per_chan[i]) reads_per_chan[i] = 0;

        // Reset held with every channel non-empty.
        for (int c = 0; c < FIFOS_CNT; c++) fill(c, 2);
        i_empty_channels = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        repeat (2) cycle();
        check_reset_outputs("t1_reset");
        mdl_ptr = 0;
        build_expected();
        rst_n_next = 1'b1;
        cycle();
        check("t1_rd_en_idle", 64'(o_rd_en_channels), 64'(0));
        cycle();
        check("t1_rd_en_grant", 64'(o_rd_en_channels), 64'(0));
        cycle();
        check("t1_rd_en_first", 64'(o_rd_en_channels), 64'(5'b00001));
        drain(200, "t1");

        // Single channel with 40 words: bursts 16/16/8, one word per clock within a burst.
        tput_on = 1'b1;
        have_prev = 1'b0;
        fill(2, 40);
        build_expected();
        drain(400, "t2");
        tput_on = 1'b0;

        // All channels with 20 words each.
        for (int c = 0; c < FIFOS_CNT; c++) fill(c, 20);
        build_expected();
        drain(800, "t3");

        // Random backpressure, three channels.
        ready_pct = 30;
        fill(0, int'($urandom_range(10, 25)));
        fill(2, int'($urandom_range(10, 25)));
        fill(4, int'($urandom_range(10, 25)));
        build_expected();
        drain(3000, "t4");
        ready_pct = 100;

        // Move the pointer to 2 via a ch1-only burst, then ch4 must win before ch1.
        fill(1, 3);
        build_expected();
        drain(100, "t5a");
        fill(4, 5);
        fill(1, 4);
        build_expected();
        drain(200, "t5b");

        // Reset at beat 5 of a ch3 burst; the next grant restarts from ch0.
        fill(3, 12);
        build_expected();
        reads_per_chan[3] = 0;
        n = 0;
        while (reads_per_chan[3] < 5 && n < 50) begin
            cycle();
            n++;
        end
        check("t6_beat5_reached", 64'(reads_per_chan[3] >= 5), 64'(1));
        fill(0, 6);
        ready_pct = 0;
        rst_n_next = 1'b0;
        cycle();
        ready_pct = 100;
        rst_n_next = 1'b1;
        cycle();
        check_reset_outputs("t6_reset");
        exp_q.delete();
        have_prev = 1'b0;
        stalled_prev = 1'b0;
        mdl_ptr = 0;
        build_expected();
        drain(300, "t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
